// File: rtl/sequenciador_pilha_pkg.sv
// Shared definitions for the stack-machine sequencer: opcodes, ALU function
// codes, error codes, FSM encoding and the opcode-to-ALU decode.
package sequenciador_pilha_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    localparam logic [2:0] ULA_ADD = 3'd0;
    localparam logic [2:0] ULA_SUB = 3'd1;
    localparam logic [2:0] ULA_AND = 3'd2;
    localparam logic [2:0] ULA_OR  = 3'd3;
    localparam logic [2:0] ULA_NOT = 3'd4;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_POP1 = 3'd2,
        ST_CAP1 = 3'd3,
        ST_POP2 = 3'd4,
        ST_CAP2 = 3'd5,
        ST_EXEC = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    function automatic logic [2:0] ula_func(input logic [2:0] op);
        logic [2:0] f;
        case (op)
            OP_ADD:  f = ULA_ADD;
            OP_SUB:  f = ULA_SUB;
            OP_AND:  f = ULA_AND;
            OP_OR:   f = ULA_OR;
            OP_NOT:  f = ULA_NOT;
            default: f = ULA_ADD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sequenciador_pilha_if.sv
// Bus bundle between the sequencer and its environment (control unit,
// operand stack and ALU). slave = sequencer side, master = environment side.
interface sequenciador_pilha_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) ();
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [DATA_W-1:0] instr_imm;
    logic              pilha_push;
    logic              pilha_pop;
    logic [DATA_W-1:0] pilha_din;
    logic [DATA_W-1:0] pilha_dout;
    logic [DATA_W-1:0] ula_a;
    logic [DATA_W-1:0] ula_b;
    logic [2:0]        ula_op;
    logic [DATA_W-1:0] ula_res;
    logic              done;
    logic [DATA_W-1:0] resultado;
    logic [CNT_W-1:0]  profundidade;
    logic              erro;
    logic [1:0]        erro_cod;

    modport slave (
        input  instr_valid, instr_op, instr_imm, pilha_dout, ula_res,
        output instr_ready, pilha_push, pilha_pop, pilha_din,
               ula_a, ula_b, ula_op, done, resultado, profundidade,
               erro, erro_cod
    );

    modport master (
        output instr_valid, instr_op, instr_imm, pilha_dout, ula_res,
        input  instr_ready, pilha_push, pilha_pop, pilha_din,
               ula_a, ula_b, ula_op, done, resultado, profundidade,
               erro, erro_cod
    );
endinterface

// File: rtl/sequenciador_pilha.sv
// Stack-machine execution sequencer: accepts one instruction at a time,
// sequences stack pops/pushes around the ALU and guards depth limits.
module sequenciador_pilha
    import sequenciador_pilha_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    sequenciador_pilha_if.slave bus
);

    state_t            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [CNT_W-1:0]  r_depth;
    logic              r_erro;
    logic [1:0]        r_erro_cod;
    logic [DATA_W-1:0] r_resultado;
    logic              r_nop_done;

    logic [CNT_W-1:0]  w_need;
    logic              w_underflow;
    logic              w_overflow;

    // Operand count required by the offered opcode, used for the underflow guard.
    always_comb begin
        w_need = {CNT_W{1'b0}};
        case (bus.instr_op)
            OP_POP, OP_NOT:                 w_need = CNT_W'(1);
            OP_ADD, OP_SUB, OP_AND, OP_OR:  w_need = CNT_W'(2);
            default:                        w_need = {CNT_W{1'b0}};
        endcase
    end

    assign w_underflow = (r_depth < w_need);
    assign w_overflow  = (bus.instr_op == OP_PUSH) && (r_depth == CNT_W'(DEPTH));

    // Sequencer FSM with depth counter, operand capture and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_imm       <= {DATA_W{1'b0}};
            r_a         <= {DATA_W{1'b0}};
            r_b         <= {DATA_W{1'b0}};
            r_depth     <= {CNT_W{1'b0}};
            r_erro      <= 1'b0;
            r_erro_cod  <= ERR_NONE;
            r_resultado <= {DATA_W{1'b0}};
            r_nop_done  <= 1'b0;
        end else begin
            r_nop_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        r_op  <= bus.instr_op;
                        r_imm <= bus.instr_imm;
                        if (w_underflow) begin
                            r_state    <= ST_ERR;
                            r_erro     <= 1'b1;
                            r_erro_cod <= ERR_UNDER;
                        end else if (w_overflow) begin
                            r_state    <= ST_ERR;
                            r_erro     <= 1'b1;
                            r_erro_cod <= ERR_OVER;
                        end else if (bus.instr_op == OP_NOP) begin
                            r_nop_done <= 1'b1;
                        end else if (bus.instr_op == OP_PUSH) begin
                            r_state <= ST_PUSH;
                        end else begin
                            r_state <= ST_POP1;
                        end
                    end
                end
                ST_PUSH: begin
                    r_resultado <= r_imm;
                    r_depth     <= r_depth + CNT_W'(1);
                    r_state     <= ST_IDLE;
                end
                ST_POP1: begin
                    r_depth <= r_depth - CNT_W'(1);
                    r_state <= ST_CAP1;
                end
                ST_CAP1: begin
                    r_b <= bus.pilha_dout;
                    if (r_op == OP_POP) begin
                        r_resultado <= bus.pilha_dout;
                        r_state     <= ST_IDLE;
                    end else if (r_op == OP_NOT) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_POP2;
                    end
                end
                ST_POP2: begin
                    r_depth <= r_depth - CNT_W'(1);
                    r_state <= ST_CAP2;
                end
                ST_CAP2: begin
                    r_a     <= bus.pilha_dout;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_resultado <= bus.ula_res;
                    r_depth     <= r_depth + CNT_W'(1);
                    r_state     <= ST_IDLE;
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode; the retire cycle forwards the value being retired.
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.pilha_push  = 1'b0;
        bus.pilha_pop   = 1'b0;
        bus.pilha_din   = {DATA_W{1'b0}};
        bus.ula_a       = {DATA_W{1'b0}};
        bus.ula_b       = {DATA_W{1'b0}};
        bus.ula_op      = 3'd0;
        bus.done        = r_nop_done;
        bus.resultado   = r_resultado;
        case (r_state)
            ST_IDLE: bus.instr_ready = 1'b1;
            ST_PUSH: begin
                bus.pilha_push = 1'b1;
                bus.pilha_din  = r_imm;
                bus.done       = 1'b1;
                bus.resultado  = r_imm;
            end
            ST_POP1: bus.pilha_pop = 1'b1;
            ST_CAP1: begin
                if (r_op == OP_POP) begin
                    bus.done      = 1'b1;
                    bus.resultado = bus.pilha_dout;
                end else begin
                    bus.done = 1'b0;
                end
            end
            ST_POP2: bus.pilha_pop = 1'b1;
            ST_EXEC: begin
                bus.ula_op = ula_func(r_op);
                if (r_op == OP_NOT) begin
                    bus.ula_a = r_b;
                    bus.ula_b = {DATA_W{1'b0}};
                end else begin
                    bus.ula_a = r_a;
                    bus.ula_b = r_b;
                end
                bus.pilha_push = 1'b1;
                bus.pilha_din  = bus.ula_res;
                bus.resultado  = bus.ula_res;
                bus.done       = 1'b1;
            end
            default: bus.instr_ready = 1'b0;
        endcase
    end

    assign bus.profundidade = r_depth;
    assign bus.erro         = r_erro;
    assign bus.erro_cod     = r_erro_cod;

endmodule

// File: tb/tb_sequenciador_pilha.sv
// Directed bench for sequenciador_pilha with a behavioural 16x16 stack and ALU.
module tb_sequenciador_pilha;
    import sequenciador_pilha_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   push_cnt = 0;
    int   pop_cnt = 0;
    int   both_cnt = 0;
    int   pc;

    sequenciador_pilha_if #(.DATA_W(16), .CNT_W(5)) bus ();

    sequenciador_pilha #(.DATA_W(16), .DEPTH(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [16];
    logic [4:0]  sp;
    logic [15:0] dout;

    always @(posedge clk) begin
        if (rst) begin
            sp   <= 5'd0;
            dout <= 16'h0000;
        end else if (bus.pilha_push && sp < 5'd16) begin
            mem[sp[3:0]] <= bus.pilha_din;
            sp <= sp + 5'd1;
        end else if (bus.pilha_pop && sp > 5'd0) begin
            dout <= mem[sp[3:0] - 4'd1];
            sp   <= sp - 5'd1;
        end
    end

    always @(posedge clk) begin
        if (bus.pilha_push) push_cnt <= push_cnt + 1;
        if (bus.pilha_pop)  pop_cnt  <= pop_cnt + 1;
        if (bus.pilha_push && bus.pilha_pop) both_cnt <= both_cnt + 1;
    end

    assign bus.pilha_dout = dout;

    always_comb begin
        case (bus.ula_op)
            3'd0:    bus.ula_res = bus.ula_a + bus.ula_b;
            3'd1:    bus.ula_res = bus.ula_a - bus.ula_b;
            3'd2:    bus.ula_res = bus.ula_a & bus.ula_b;
            3'd3:    bus.ula_res = bus.ula_a | bus.ula_b;
            3'd4:    bus.ula_res = ~bus.ula_a;
            default: bus.ula_res = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] imm);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_imm   = imm;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_imm   = 16'h0000;
    endtask

    task automatic push_v(input logic [15:0] v);
        issue(OP_PUSH, v);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_imm   = 16'h0000;
        do_reset();

        chk("rst_ready",  32'(bus.instr_ready),  32'd1);
        chk("rst_depth",  32'(bus.profundidade), 32'd0);
        chk("rst_erro",   32'(bus.erro),         32'd0);
        chk("rst_cod",    32'(bus.erro_cod),     32'd0);
        chk("rst_res",    32'(bus.resultado),    32'd0);
        chk("rst_done",   32'(bus.done),         32'd0);
        chk("rst_push",   32'(bus.pilha_push),   32'd0);
        chk("rst_pop",    32'(bus.pilha_pop),    32'd0);
        chk("rst_ula_a",  32'(bus.ula_a),        32'd0);
        chk("rst_ula_b",  32'(bus.ula_b),        32'd0);
        chk("rst_ula_op", 32'(bus.ula_op),       32'd0);

        // ADD on empty stack: underflow, absorbing error state
        pc = pop_cnt;
        issue(OP_ADD, 16'h0000);
        chk("uf_erro",  32'(bus.erro),        32'd1);
        chk("uf_cod",   32'(bus.erro_cod),    32'd1);
        chk("uf_ready", 32'(bus.instr_ready), 32'd0);
        chk("uf_done",  32'(bus.done),        32'd0);
        bus.instr_valid = 1'b1;
        bus.instr_op    = OP_PUSH;
        bus.instr_imm   = 16'h1234;
        tick();
        tick();
        tick();
        bus.instr_valid = 1'b0;
        chk("uf_ready_hold", 32'(bus.instr_ready),  32'd0);
        chk("uf_depth",      32'(bus.profundidade), 32'd0);
        chk("uf_no_pop",     32'(pop_cnt - pc),     32'd0);
        chk("uf_no_push",    32'(push_cnt),         32'd0);
        do_reset();
        chk("uf_clr_erro",  32'(bus.erro),        32'd0);
        chk("uf_clr_ready", 32'(bus.instr_ready), 32'd1);

        issue(OP_NOP, 16'h0000);
        chk("nop_done",  32'(bus.done),         32'd1);
        chk("nop_ready", 32'(bus.instr_ready),  32'd1);
        chk("nop_depth", 32'(bus.profundidade), 32'd0);
        tick();
        chk("nop_done_clr", 32'(bus.done), 32'd0);

        // PUSH 5, PUSH 3, SUB -> 2
        issue(OP_PUSH, 16'h0005);
        chk("push_strobe", 32'(bus.pilha_push), 32'd1);
        chk("push_din",    32'(bus.pilha_din),  32'h5);
        chk("push_done",   32'(bus.done),       32'd1);
        chk("push_res",    32'(bus.resultado),  32'h5);
        tick();
        chk("push_depth", 32'(bus.profundidade), 32'd1);
        push_v(16'h0003);
        issue(OP_SUB, 16'h0000);
        chk("sub_c1_pop",   32'(bus.pilha_pop),    32'd1);
        chk("sub_c1_depth", 32'(bus.profundidade), 32'd2);
        chk("sub_c1_ready", 32'(bus.instr_ready),  32'd0);
        tick();
        chk("sub_c2_pop",  32'(bus.pilha_pop), 32'd0);
        chk("sub_c2_done", 32'(bus.done),      32'd0);
        tick();
        chk("sub_c3_pop", 32'(bus.pilha_pop), 32'd1);
        tick();
        chk("sub_c4_pop",  32'(bus.pilha_pop), 32'd0);
        chk("sub_c4_done", 32'(bus.done),      32'd0);
        tick();
        chk("sub_c5_done",  32'(bus.done),         32'd1);
        chk("sub_c5_push",  32'(bus.pilha_push),   32'd1);
        chk("sub_c5_din",   32'(bus.pilha_din),    32'h2);
        chk("sub_c5_res",   32'(bus.resultado),    32'h2);
        chk("sub_c5_a",     32'(bus.ula_a),        32'h5);
        chk("sub_c5_b",     32'(bus.ula_b),        32'h3);
        chk("sub_c5_op",    32'(bus.ula_op),       32'd1);
        chk("sub_c5_depth", 32'(bus.profundidade), 32'd0);
        tick();
        chk("sub_done_clr", 32'(bus.done),         32'd0);
        chk("sub_res_hold", 32'(bus.resultado),    32'h2);
        chk("sub_depth",    32'(bus.profundidade), 32'd1);
        chk("sub_ready",    32'(bus.instr_ready),  32'd1);

        // PUSH 0x00FF, NOT -> 0xFF00
        do_reset();
        push_v(16'h00FF);
        issue(OP_NOT, 16'h0000);
        chk("not_c1_pop", 32'(bus.pilha_pop), 32'd1);
        tick();
        chk("not_c2_done", 32'(bus.done), 32'd0);
        tick();
        chk("not_c3_done", 32'(bus.done),       32'd1);
        chk("not_c3_a",    32'(bus.ula_a),      32'h00FF);
        chk("not_c3_b",    32'(bus.ula_b),      32'h0);
        chk("not_c3_op",   32'(bus.ula_op),     32'd4);
        chk("not_c3_push", 32'(bus.pilha_push), 32'd1);
        chk("not_c3_din",  32'(bus.pilha_din),  32'hFF00);
        tick();
        chk("not_depth", 32'(bus.profundidade), 32'd1);
        chk("not_res",   32'(bus.resultado),    32'hFF00);

        // PUSH 0xFFFF, PUSH 1, ADD wraps to 0; then POP
        do_reset();
        push_v(16'hFFFF);
        push_v(16'h0001);
        issue(OP_ADD, 16'h0000);
        tick();
        tick();
        tick();
        tick();
        chk("add_done", 32'(bus.done),      32'd1);
        chk("add_din",  32'(bus.pilha_din), 32'h0);
        chk("add_op",   32'(bus.ula_op),    32'd0);
        chk("add_erro", 32'(bus.erro),      32'd0);
        tick();
        chk("add_depth", 32'(bus.profundidade), 32'd1);
        issue(OP_POP, 16'h0000);
        chk("pop_c1_pop",  32'(bus.pilha_pop), 32'd1);
        chk("pop_c1_done", 32'(bus.done),      32'd0);
        tick();
        chk("pop_c2_done",  32'(bus.done),         32'd1);
        chk("pop_c2_res",   32'(bus.resultado),    32'h0);
        chk("pop_c2_depth", 32'(bus.profundidade), 32'd0);
        tick();
        chk("pop_done_clr", 32'(bus.done),        32'd0);
        chk("pop_ready",    32'(bus.instr_ready), 32'd1);

        // Fill to 16 then overflow
        do_reset();
        for (int i = 0; i < 16; i++) push_v(16'h1000 + 16'(i));
        chk("full_depth", 32'(bus.profundidade), 32'd16);
        pc = push_cnt;
        issue(OP_PUSH, 16'hBEEF);
        chk("of_erro",  32'(bus.erro),        32'd1);
        chk("of_cod",   32'(bus.erro_cod),    32'd2);
        chk("of_push",  32'(bus.pilha_push),  32'd0);
        chk("of_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        chk("of_depth",    32'(bus.profundidade), 32'd16);
        chk("of_no_push",  32'(push_cnt - pc),    32'd0);

        // PUSH 7, PUSH 9, OR; reset while in CAP2
        do_reset();
        push_v(16'h0007);
        push_v(16'h0009);
        issue(OP_OR, 16'h0000);
        tick();
        tick();
        tick();
        chk("mid_cap2_ready", 32'(bus.instr_ready), 32'd0);
        pc = push_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ready", 32'(bus.instr_ready),  32'd1);
        chk("mid_depth", 32'(bus.profundidade), 32'd0);
        chk("mid_erro",  32'(bus.erro),         32'd0);
        chk("mid_push",  32'(bus.pilha_push),   32'd0);
        chk("mid_done",  32'(bus.done),         32'd0);
        tick();
        chk("mid_no_push", 32'(push_cnt - pc), 32'd0);

        chk("push_pop_exclusive", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequenciador_pilha.md
Name: sequenciador_pilha

Overview:
- Stack-machine execution sequencer between the control unit and the 16x16 operand stack and ALU.
- Accepts one stack instruction at a time: NOP, PUSH immediate, POP, or an ALU operation.
- For an ALU operation it pops operands, drives the ALU, and pushes the result.
- Tracks stack depth, blocks underflow and overflow before any stack access, and reports errors to the control unit.

Parameters:
- DATA_W, 16: data width of the stack, immediate and ALU.
- DEPTH, 16: stack capacity in entries.
- CNT_W, 5: depth counter width; must hold 0..DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset; shared with the stack so both clear together
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept; transfer when valid && ready at the clk edge
- instr_op  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 NOT
- instr_imm  in  DATA_W  PUSH operand, sampled at accept
- pilha_push  out  1  stack write strobe, one cycle per entry
- pilha_pop  out  1  stack read strobe; stack output is valid the following cycle
- pilha_din  out  DATA_W  data to push
- pilha_dout  in  DATA_W  registered stack output
- ula_a  out  DATA_W  ALU operand A (deeper entry)
- ula_b  out  DATA_W  ALU operand B (former top)
- ula_op  out  3  ALU function code, from the shared package
- ula_res  in  DATA_W  combinational ALU result
- done  out  1  one-cycle pulse when an instruction retires
- resultado  out  DATA_W  value popped by POP, or ALU result pushed; held until next retire
- profundidade  out  CNT_W  current stack depth
- erro  out  1  sticky error flag
- erro_cod  out  2  01 underflow, 10 overflow, 00 none

Behaviour:
- **Reset:**
  - State goes to IDLE.
  - profundidade=0, erro=0, erro_cod=00, resultado=0, done=0, pilha_push=0, pilha_pop=0.
  - ula_a, ula_b and ula_op are 0.
- **Outputs:** Moore-decoded from state and registers. pilha_push and pilha_pop are never both 1.
- **States:** IDLE, PUSH, POP1, CAP1, POP2, CAP2, EXEC, ERR.
- **IDLE:**
  - instr_ready=1.
  - On accept, latch op and imm, then run the error checks first:
    - POP or NOT with depth<1: underflow.
    - ADD/SUB/AND/OR with depth<2: underflow.
    - PUSH with depth==DEPTH: overflow.
  - On any error: next state ERR, erro=1, erro_cod latched, no stack strobe, no done.
  - NOP: done=1 in the cycle after accept, stays in IDLE.
- **PUSH:**
  - pilha_push=1, pilha_din=imm, done=1, resultado=imm.
  - Then IDLE.
  - Retires 1 cycle after accept.
- **POP1:** pilha_pop=1. Then CAP1.
- **CAP1:** sample pilha_dout into reg_b.
  - POP: resultado=pilha_dout, done=1, then IDLE. Retires 2 cycles after accept.
  - NOT: go to EXEC.
  - Binary ops: go to POP2.
- **POP2:** pilha_pop=1. Then CAP2.
- **CAP2:** sample pilha_dout into reg_a. Then EXEC.
- **EXEC:**
  - ula_a=reg_a, ula_b=reg_b, ula_op=function.
  - For NOT: ula_a=reg_b and ula_b=0.
  - pilha_push=1, pilha_din=ula_res, resultado=ula_res, done=1.
  - Then IDLE.
  - Binary ops retire 5 cycles after accept; NOT retires 3.
- **instr_ready:** 1 only in IDLE; 0 in all other states including ERR.
- **Depth counter:** +1 at the edge ending a pilha_push cycle, -1 at the edge ending a pilha_pop cycle. The checks guarantee 0..DEPTH, so it never wraps.
- **Arithmetic:**
  - Width is DATA_W, modulo 2^DATA_W; no carry or flags.
  - SUB is A-B, where A is the deeper entry.
- **ERR:** absorbing; only rst leaves it. Stack is untouched, so profundidade is unchanged.
- **Reset mid-instruction:** any state goes to IDLE. Partially popped operands are discarded and depth is 0, consistent with the stack reset.
- **instr_valid outside IDLE:** ignored. The input is not sampled and need not be held stable.

Decomposition:
- Shared package (pilha_pkg):
  - Opcode constants OP_NOP..OP_NOT.
  - ALU function constants ULA_ADD=0, ULA_SUB=1, ULA_AND=2, ULA_OR=3, ULA_NOT=4.
  - erro_cod values.
  - State encoding.
- No sub-module. The depth counter and checks are inline. The opcode-to-ula_op decode is a combinational function in the package.

Test Plan:
- PUSH 5, PUSH 3, SUB → pops at post-accept cycles 1 and 3; EXEC pushes 0x0002; resultado=0x0002; profundidade 2→1; done exactly 5 cycles after SUB accept.
- After reset, ADD → erro=1, erro_cod=01; no pilha_pop ever; instr_ready stays 0; a subsequent PUSH is not accepted until rst.
- 16 PUSHes of 0x1000+i reach profundidade=16; 17th PUSH → erro_cod=10, no pilha_push, depth stays 16.
- PUSH 0x00FF, NOT → ula_a=0x00FF, ula_op=ULA_NOT; push of 0xFF00; depth stays 1; done 3 cycles after accept.
- PUSH 0xFFFF, PUSH 0x0001, ADD → 0x0000 wraps with no error; then POP → resultado=0x0000, depth 0, done 2 cycles after accept.
- PUSH 7, PUSH 9, OR, then rst asserted in CAP2 → next cycle IDLE, profundidade=0, no pilha_push issued, erro=0, instr_ready=1.
